// File: rtl/mem_swap_pkg.sv
// Shared definitions for the register-file swap scheduler: FSM state encoding
// and the write-client identifiers used by the round-robin arbiter.
package mem_swap_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD_A = 2'd1;
   localparam logic [1:0] S_XFER = 2'd2;
   localparam logic [1:0] S_WR_B = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_RD_A = S_RD_A,
      ST_XFER = S_XFER,
      ST_WR_B = S_WR_B
   } state_e;

   localparam logic CLIENT0 = 1'b0;
   localparam logic CLIENT1 = 1'b1;

endpackage

// File: rtl/mem_swap_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter: combinational one-hot grant, with the
// last contended winner remembered so that ties alternate.
module rr_arb2
   import mem_swap_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic rr_last_q;
   logic rr_last_d;

   // NOTE: every signal written in always_comb gets a default first, otherwise
   // a path that skips the assignment infers a latch.
   always_comb begin
      gnt       = 2'b00;
      rr_last_d = rr_last_q;
      case (req)
         2'b01: gnt = 2'b01;
         2'b10: gnt = 2'b10;
         2'b11: begin
            // Only contended grants move the round-robin pointer.
            if (rr_last_q == CLIENT0) begin
               gnt       = 2'b10;
               rr_last_d = CLIENT1;
            end else begin
               gnt       = 2'b01;
               rr_last_d = CLIENT0;
            end
         end
         default: gnt = 2'b00;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; blocking ones
   // here would make the result depend on process evaluation order.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_last_q <= CLIENT1;
      end else begin
         rr_last_q <= rr_last_d;
      end
   end

endmodule

// File: rtl/mem_swap_scheduler.sv
// Single owner of the 1R/1W register file ports: arbitrates two client writers,
// passes one read address through, and runs atomic 3-cycle A<->B swaps.
module mem_swap_scheduler
   import mem_swap_pkg::*;
#(
   parameter int addr_w_N    = 7,
   parameter int data_w_Bits = 8
) (
   input  logic                   clk,
   input  logic                   reset,

   input  logic                   swap_req,
   input  logic [addr_w_N-1:0]    swap_addr_A,
   input  logic [addr_w_N-1:0]    swap_addr_B,
   output logic                   swap_ack,
   output logic                   busy,

   input  logic                   c0_we,
   input  logic [addr_w_N-1:0]    c0_addr,
   input  logic [data_w_Bits-1:0] c0_data,
   output logic                   c0_gnt,

   input  logic                   c1_we,
   input  logic [addr_w_N-1:0]    c1_addr,
   input  logic [data_w_Bits-1:0] c1_data,
   output logic                   c1_gnt,

   input  logic [addr_w_N-1:0]    rd_addr,
   output logic [data_w_Bits-1:0] rd_data,
   output logic                   rd_valid,

   output logic                   rf_we,
   output logic [addr_w_N-1:0]    rf_address_w,
   output logic [addr_w_N-1:0]    rf_address_r,
   output logic [data_w_Bits-1:0] rf_data_w,
   input  logic [data_w_Bits-1:0] rf_data_r
);

   state_e                  state_q,  state_d;
   logic [addr_w_N-1:0]     addr_a_q, addr_a_d;
   logic [addr_w_N-1:0]     addr_b_q, addr_b_d;
   logic [data_w_Bits-1:0]  tmp_q,    tmp_d;

   logic [1:0]              arb_req;
   logic [1:0]              arb_gnt;

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (arb_req),
      .gnt   (arb_gnt)
   );

   assign c0_gnt  = arb_gnt[0];
   assign c1_gnt  = arb_gnt[1];
   assign rd_data = rf_data_r;

   always_comb begin
      state_d      = state_q;
      addr_a_d     = addr_a_q;
      addr_b_d     = addr_b_q;
      tmp_d        = tmp_q;
      arb_req      = 2'b00;
      rf_we        = 1'b0;
      rf_address_w = '0;
      rf_data_w    = '0;
      rf_address_r = rd_addr;
      rd_valid     = 1'b0;
      swap_ack     = 1'b0;
      busy         = 1'b1;

      case (state_q)
         ST_IDLE: begin
            busy     = 1'b0;
            rd_valid = 1'b1;
            // Client writes are only arbitrated in IDLE and never during reset.
            arb_req  = {c1_we, c0_we} & {2{~reset}};
            if (arb_gnt[0]) begin
               rf_we        = 1'b1;
               rf_address_w = c0_addr;
               rf_data_w    = c0_data;
            end else if (arb_gnt[1]) begin
               rf_we        = 1'b1;
               rf_address_w = c1_addr;
               rf_data_w    = c1_data;
            end
            if (swap_req) begin
               addr_a_d = swap_addr_A;
               addr_b_d = swap_addr_B;
               state_d  = ST_RD_A;
            end
         end
         ST_RD_A: begin
            rf_address_r = addr_a_q;
            tmp_d        = rf_data_r;
            state_d      = ST_XFER;
         end
         ST_XFER: begin
            // mem[A] <= mem[B] straight through the combinational read port.
            rf_address_r = addr_b_q;
            rf_we        = 1'b1;
            rf_address_w = addr_a_q;
            rf_data_w    = rf_data_r;
            state_d      = ST_WR_B;
         end
         ST_WR_B: begin
            rf_we        = 1'b1;
            rf_address_w = addr_b_q;
            rf_data_w    = tmp_q;
            swap_ack     = 1'b1;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: only control and datapath registers live here; the register file
   // itself is outside and is never cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         addr_a_q <= '0;
         addr_b_q <= '0;
         tmp_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_a_q <= addr_a_d;
         addr_b_q <= addr_b_d;
         tmp_q    <= tmp_d;
      end
   end

endmodule

// File: tb/tb_mem_swap_scheduler.sv
// Directed bench for mem_swap_scheduler: behavioural register file, expected
// write/ack events queued by stimulus and popped by a negedge monitor.
module tb_mem_swap_scheduler;

   localparam int AW = 7;
   localparam int DW = 8;

   typedef enum logic [1:0] {EV_G0 = 2'd0, EV_G1 = 2'd1, EV_ACK = 2'd2} ev_kind_e;
   typedef struct {
      ev_kind_e       kind;
      logic [AW-1:0]  addr;
      logic [DW-1:0]  data;
   } ev_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          swap_req = 1'b0;
   logic [AW-1:0] swap_addr_A = '0, swap_addr_B = '0;
   logic          swap_ack, busy;
   logic          c0_we = 1'b0, c1_we = 1'b0;
   logic [AW-1:0] c0_addr = '0, c1_addr = '0;
   logic [DW-1:0] c0_data = '0, c1_data = '0;
   logic          c0_gnt, c1_gnt;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          rf_we;
   logic [AW-1:0] rf_address_w, rf_address_r;
   logic [DW-1:0] rf_data_w, rf_data_r;

   logic          pre_we = 1'b0;
   logic [AW-1:0] pre_addr = '0;
   logic [DW-1:0] pre_data = '0;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   int  checks   = 0;
   int  failures = 0;
   ev_t exp_q[$];

   always #5 clk = ~clk;

   mem_swap_scheduler #(.addr_w_N(AW), .data_w_Bits(DW)) dut (
      .clk(clk), .reset(reset),
      .swap_req(swap_req), .swap_addr_A(swap_addr_A), .swap_addr_B(swap_addr_B),
      .swap_ack(swap_ack), .busy(busy),
      .c0_we(c0_we), .c0_addr(c0_addr), .c0_data(c0_data), .c0_gnt(c0_gnt),
      .c1_we(c1_we), .c1_addr(c1_addr), .c1_data(c1_data), .c1_gnt(c1_gnt),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .rf_we(rf_we), .rf_address_w(rf_address_w), .rf_address_r(rf_address_r),
      .rf_data_w(rf_data_w), .rf_data_r(rf_data_r)
   );

   // Register file model: combinational read, write on the rising edge.
   assign rf_data_r = mem[rf_address_r];
   always @(posedge clk) begin
      if (rf_we) mem[rf_address_w] <= rf_data_w;
      else if (pre_we) mem[pre_addr] <= pre_data;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input ev_kind_e kind, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      ev_t e;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      pre_we   = 1'b1;
      pre_addr = addr;
      pre_data = data;
      step();
      pre_we   = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
      rd_addr = addr;
      @(negedge clk);
      check({name, "_valid"}, 32'(rd_valid), 32'd1);
      check(name, 32'(rd_data), 32'(exp));
      step();
   endtask

   // Accepts a swap and walks its three busy cycles; c1_hold raises c1_we
   // right after acceptance so it must wait for the swap to finish.
   task automatic run_swap(input string name, input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [DW-1:0] old_a, input logic c1_hold);
      swap_req    = 1'b1;
      swap_addr_A = a;
      swap_addr_B = b;
      push(EV_ACK, b, old_a);
      @(negedge clk);
      check({name, "_accept_busy"}, 32'(busy), 32'd0);
      step();
      swap_req = 1'b0;
      if (c1_hold) begin
         c1_we   = 1'b1;
         c1_addr = 7'd3;
         c1_data = 8'h33;
         push(EV_G1, 7'd3, 8'h33);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check({name, "_busy"}, 32'(busy), 32'd1);
         check({name, "_rd_valid"}, 32'(rd_valid), 32'd0);
         check({name, "_ack"}, 32'(swap_ack), 32'(i == 2));
         check({name, "_c1_gnt_blocked"}, 32'(c1_gnt), 32'd0);
         step();
      end
      if (c1_hold) begin
         @(negedge clk);
         check({name, "_c1_gnt_after"}, 32'(c1_gnt), 32'd1);
         step();
         c1_we = 1'b0;
      end
   endtask

   // Monitor: every grant or ack must match the head of the expected queue.
   always @(negedge clk) begin
      ev_t      e;
      ev_kind_e kind;
      if (!reset) begin
         check("single_grant", 32'(c0_gnt & c1_gnt), 32'd0);
         if (c0_gnt || c1_gnt || swap_ack) begin
            kind = swap_ack ? EV_ACK : (c0_gnt ? EV_G0 : EV_G1);
            if (exp_q.size() == 0) begin
               check("unexpected_event", 32'(kind) + 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("ev_kind", 32'(kind), 32'(e.kind));
               check("ev_rf_we", 32'(rf_we), 32'd1);
               check("ev_addr", 32'(rf_address_w), 32'(e.addr));
               check("ev_data", 32'(rf_data_w), 32'(e.data));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset: requests present but must not be granted.
      reset   = 1'b1;
      rd_addr = 7'h2A;
      c0_we   = 1'b1; c0_addr = 7'd1; c0_data = 8'hA0;
      c1_we   = 1'b1; c1_addr = 7'd2; c1_data = 8'hB0;
      step();
      step();
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ack", 32'(swap_ack), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd1);
      check("rst_rf_we", 32'(rf_we), 32'd0);
      check("rst_gnts", 32'({c1_gnt, c0_gnt}), 32'd0);
      check("rst_rf_address_r", 32'(rf_address_r), 32'h2A);
      step();

      // Contention: ties alternate, client 0 first after reset.
      reset = 1'b0;
      push(EV_G0, 7'd1, 8'hA0);
      push(EV_G1, 7'd2, 8'hB0);
      push(EV_G0, 7'd1, 8'hA0);
      push(EV_G1, 7'd2, 8'hB0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rr_c0_gnt", 32'(c0_gnt), 32'((i % 2) == 0));
         step();
      end
      c0_we = 1'b0;
      c1_we = 1'b0;
      read_check("mem1", 7'd1, 8'hA0);
      read_check("mem2", 7'd2, 8'hB0);

      // Plain swap 5/9.
      preload(7'd5, 8'h11);
      preload(7'd9, 8'h22);
      run_swap("swap", 7'd5, 7'd9, 8'h11, 1'b0);
      read_check("swap_mem5", 7'd5, 8'h22);
      read_check("swap_mem9", 7'd9, 8'h11);

      // Swap back with client 1 waiting on addr 3.
      run_swap("swapw", 7'd5, 7'd9, 8'h22, 1'b1);
      read_check("swapw_mem5", 7'd5, 8'h11);
      read_check("swapw_mem9", 7'd9, 8'h22);
      read_check("swapw_mem3", 7'd3, 8'h33);

      // Back-to-back A == B, swap_req held until the second ack.
      preload(7'd7, 8'h5C);
      swap_req    = 1'b1;
      swap_addr_A = 7'd7;
      swap_addr_B = 7'd7;
      push(EV_ACK, 7'd7, 8'h5C);
      push(EV_ACK, 7'd7, 8'h5C);
      for (int s = 0; s < 2; s++) begin
         @(negedge clk);
         check("b2b_idle_busy", 32'(busy), 32'd0);
         step();
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b2b_busy", 32'(busy), 32'd1);
            check("b2b_ack", 32'(swap_ack), 32'(i == 2));
            if (s == 1 && i == 2) swap_req = 1'b0;
            step();
         end
      end
      @(negedge clk);
      check("b2b_done_busy", 32'(busy), 32'd0);
      step();
      @(negedge clk);
      check("b2b_no_restart", 32'(busy), 32'd0);
      step();
      read_check("b2b_mem7", 7'd7, 8'h5C);

      // Reset during XFER: XFER write lands, no ack, c0 served right after.
      swap_req    = 1'b1;
      swap_addr_A = 7'd5;
      swap_addr_B = 7'd9;
      step();
      swap_req = 1'b0;
      step();
      reset   = 1'b1;
      c0_we   = 1'b1; c0_addr = 7'h10; c0_data = 8'h77;
      @(negedge clk);
      check("xfer_busy", 32'(busy), 32'd1);
      check("xfer_ack", 32'(swap_ack), 32'd0);
      step();
      reset = 1'b0;
      push(EV_G0, 7'h10, 8'h77);
      @(negedge clk);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_ack", 32'(swap_ack), 32'd0);
      check("rst_mid_c0_gnt", 32'(c0_gnt), 32'd1);
      step();
      c0_we = 1'b0;
      read_check("rst_mid_mem5", 7'd5, 8'h22);
      read_check("rst_mid_mem9", 7'd9, 8'h22);
      read_check("rst_mid_mem10", 7'h10, 8'h77);

      step();
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_swap_scheduler.md
Name: mem_swap_scheduler

Overview:
- Sequencer and arbiter in front of the 1-read/1-write register file.
- Shares the write port between two client writers.
- Executes atomic A<->B swaps as a fixed 3-cycle read/transfer/write sequence.
- Passes a single read address through to the file.
- Sits between the client logic and the Register_File instance; replaces the ad-hoc mux selection with one owner of the RF ports.

Parameters:
- addr_w_N, 7, register file address width (2^addr_w_N entries)
- data_w_Bits, 8, data word width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- swap_req  in  1  swap request (level); sampled only in IDLE
- swap_addr_A  in  addr_w_N  first swap address; sampled with swap_req
- swap_addr_B  in  addr_w_N  second swap address; sampled with swap_req
- swap_ack  out  1  high for exactly the WR_B cycle of each swap
- busy  out  1  high in any non-IDLE state
- c0_we  in  1  client 0 write request
- c0_addr  in  addr_w_N  client 0 write address
- c0_data  in  data_w_Bits  client 0 write data
- c0_gnt  out  1  client 0 write performed at this clock edge
- c1_we, c1_addr, c1_data, c1_gnt  same as client 0, for client 1
- rd_addr  in  addr_w_N  client read address
- rd_data  out  data_w_Bits  equals rf_data_r
- rd_valid  out  1  high when rd_data reflects rd_addr (IDLE only)
- rf_we  out  1  to RF write enable
- rf_address_w  out  addr_w_N  to RF write address
- rf_address_r  out  addr_w_N  to RF read address
- rf_data_w  out  data_w_Bits  to RF write data
- rf_data_r  in  data_w_Bits  from RF; combinational read of rf_address_r

Behaviour:
- States: IDLE, RD_A, XFER, WR_B; 2-bit encoding.
- Reset:
  - state=IDLE; addr_A_q, addr_B_q, tmp_q = 0; rr_last = 1 (client 0 wins first tie).
  - All outputs low/zero, except rd_valid=1 and rf_address_r=rd_addr.
- IDLE:
  - rf_address_r = rd_addr; rd_valid = 1.
  - Write port arbitration:
    - Only c0_we → grant client 0.
    - Only c1_we → grant client 1.
    - Both → grant the client not equal to rr_last; update rr_last to the granted client.
    - Grant is combinational: cN_gnt = 1, rf_we = 1, rf_address_w/rf_data_w from the granted client. At most one grant per cycle.
  - swap_req = 1: latch A, B; next state = RD_A. The client write granted in this same cycle still completes.
- RD_A (cycle 1):
  - rf_address_r = addr_A_q; tmp_q <= rf_data_r; rf_we = 0.
  - No grants; rd_valid = 0.
- XFER (cycle 2):
  - rf_address_r = addr_B_q; rf_we = 1; rf_address_w = addr_A_q; rf_data_w = rf_data_r (mem[A] <= mem[B]).
  - No grants.
- WR_B (cycle 3):
  - rf_we = 1; rf_address_w = addr_B_q; rf_data_w = tmp_q; swap_ack = 1.
  - Next state = IDLE.
- Latency: swap completes 3 cycles after the accepting IDLE edge; ack is a 1-cycle pulse.
- A busy state lasts 3 cycles; client requests are held (not dropped) by clients until gnt.
- swap_req still high in the IDLE cycle after ack → new swap accepted (back-to-back). Requesters drop swap_req on ack.
- swap_req / address changes during busy are ignored; latched addresses are used.
- A == B: full sequence runs; contents unchanged; ack issued.
- Reset mid-swap: immediate return to IDLE, no ack.
  - After XFER, mem[A] may already hold the old mem[B]; this is defined, with no rollback.
- rr_last updates only on contended grants.
- rd_data is always rf_data_r, but is valid for rd_addr only when rd_valid = 1.

Decomposition:
- Shared package mem_swap_pkg: state encoding localparams (S_IDLE=0, S_RD_A=1, S_XFER=2, S_WR_B=3) and the CLIENT0/CLIENT1 identifiers.
- One sub-module, rr_arb2: 2-requester round-robin arbiter, combinational grant plus registered rr_last.
- FSM and port muxing stay in the top module.

Test Plan:
- Swap: preload mem[5]=0x11, mem[9]=0x22; pulse swap_req with A=5, B=9.
  → busy for 3 cycles; swap_ack on the 3rd; then mem[5]=0x22, mem[9]=0x11; rd_valid low throughout the swap.
- Contention: c0_we and c1_we both held for 4 cycles from reset, addresses 1/2, data 0xA0/0xB0.
  → grants alternate c0, c1, c0, c1; one rf_we per cycle.
- Writes during swap: c1_we held to addr 3 during a swap of 5/9.
  → c1_gnt = 0 in all 3 busy cycles; granted in the first IDLE cycle after; swap result intact.
- Back-to-back and A==B: swap_req held high for A=B=7 (mem[7]=0x5C).
  → two consecutive 3-cycle swaps with two ack pulses; mem[7]=0x5C.
- Reset mid-swap: assert reset in XFER of a 5/9 swap.
  → next cycle state IDLE, no swap_ack, busy=0, c0 request granted immediately after reset deasserts.
